// File: rtl/ic_fill_ctrl_if.sv
// I-cache fill controller bus bundle: cache-side miss/fill signals and memory read bus.
interface ic_fill_ctrl_if #(
    parameter int unsigned BEAT_W = 64
);
    logic              ic_miss;
    logic [31:0]       ic_miss_addr;
    logic              flush;
    logic [255:0]      ic_fill_data;
    logic              ic_miss_ack;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [BEAT_W-1:0] mem_rdata;
    logic              busy;

    // Controller side
    modport master (
        input  ic_miss, ic_miss_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
        output ic_fill_data, ic_miss_ack, mem_req, mem_addr, busy
    );

    // Cache / memory side
    modport slave (
        output ic_miss, ic_miss_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  ic_fill_data, ic_miss_ack, mem_req, mem_addr, busy
    );
endinterface

// File: rtl/ic_fill_ctrl.sv
// I-cache line fill controller: one outstanding 256-bit line read, assembled from
// BEAT_W-bit beats, then a one-cycle ack and a one-cycle hold before the next miss.
// Optional feature macro: IC_FILL_FLUSH_EN (flush aborts the ack, bus transfer still drains).
module ic_fill_ctrl #(
    parameter int unsigned BEAT_W = 64
) (
    input logic          clk,
    input logic          rst_n,
    ic_fill_ctrl_if.master bus
);
    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEATS  = LINE_W / BEAT_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] FILL = 3'd2;
    localparam logic [2:0] ACK  = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req_nxt;
    logic             ack_nxt;
    logic [31:0]      addr_nxt;
    logic             beat_we_c;
    logic             flush_c;

    // Line offset bits are zero by construction and never used
    logic [4:0] addr_lo_unused;
    assign addr_lo_unused = bus.ic_miss_addr[4:0];

`ifdef IC_FILL_FLUSH_EN
    logic abort, abort_nxt;
    assign flush_c = bus.flush;
`else
    logic flush_unused;
    assign flush_unused = bus.flush;
    assign flush_c      = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = bus.mem_req;
        ack_nxt   = 1'b0;
        addr_nxt  = bus.mem_addr;
        beat_we_c = 1'b0;
`ifdef IC_FILL_FLUSH_EN
        abort_nxt = abort;
`endif
        case (state)
            IDLE: begin
                // A miss coinciding with flush is dropped (flush_c is 0 when disabled)
                if (bus.ic_miss && !flush_c) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = {bus.ic_miss_addr[31:5], 5'b0};
                    cnt_nxt   = '0;
`ifdef IC_FILL_FLUSH_EN
                    abort_nxt = 1'b0;
`endif
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_nxt = FILL;
                    req_nxt   = 1'b0;
                end
            end
            FILL: begin
                if (bus.mem_rvalid) begin
                    beat_we_c = 1'b1;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        state_nxt = ACK;
`ifdef IC_FILL_FLUSH_EN
                        ack_nxt   = !(abort || flush_c);
`else
                        ack_nxt   = 1'b1;
`endif
                    end
                end
            end
            ACK:     state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef IC_FILL_FLUSH_EN
        if (flush_c && (state == REQ || state == FILL || state == ACK)) begin
            abort_nxt = 1'b1;
        end
`endif
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.ic_miss_ack <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            bus.mem_req     <= req_nxt;
            bus.mem_addr    <= addr_nxt;
            bus.ic_miss_ack <= ack_nxt;
            bus.busy        <= (state_nxt != IDLE);
        end
    end

    // Line assembly: only FILL beat writes change the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ic_fill_data <= '0;
        end else if (beat_we_c) begin
            bus.ic_fill_data[BEAT_W*cnt +: BEAT_W] <= bus.mem_rdata;
        end
    end

`ifdef IC_FILL_FLUSH_EN
    // Abort flag: set by flush during an outstanding fill, cleared on new miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort <= 1'b0;
        end else begin
            abort <= abort_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Directed bench for ic_fill_ctrl with a line scoreboard checked at each ack.
module tb_ic_fill_ctrl;
    localparam int unsigned BEAT_W = 64;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [255:0] sb[$];
    logic [255:0] last_line;

    ic_fill_ctrl_if #(.BEAT_W(BEAT_W)) bus ();

    ic_fill_ctrl #(.BEAT_W(BEAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [63:0] b0, input logic [63:0] b1,
                                             input logic [63:0] b2, input logic [63:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    // Drive the four beats of a line (optionally with one idle cycle between beats)
    task automatic feed_beats(input logic [255:0] line, input bit gap);
        sb.push_back(line);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = line[64*i +: 64];
            tick();
            if (gap && i < 3) begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                tick();
            end
        end
        bus.mem_rvalid = 1'b0;
    endtask

    // At the ACK cycle: ack must be high and the line must match the scoreboard head
    task automatic expect_ack(input string tag);
        logic [255:0] exp;
        exp = '0;
        if (sb.size() != 0) exp = sb.pop_front();
        chk({tag, "_ack"}, 256'(bus.ic_miss_ack), 256'd1);
        chk({tag, "_data"}, bus.ic_fill_data, exp);
        last_line = exp;
    endtask

    task automatic start_miss(input logic [31:0] addr);
        bus.ic_miss      = 1'b1;
        bus.ic_miss_addr = addr;
        tick();
        bus.ic_miss      = 1'b0;
    endtask

    initial begin
        logic [255:0] l1, l2, l3a, l3b, l4, l6;
        l1  = mk_line(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        l2  = mk_line(64'hA0A0_0001_0000_0001, 64'hA0A0_0002_0000_0002,
                      64'hA0A0_0003_0000_0003, 64'hA0A0_0004_0000_0004);
        l3a = mk_line(64'h0303_0303_0000_0001, 64'h0303_0303_0000_0002,
                      64'h0303_0303_0000_0003, 64'h0303_0303_0000_0004);
        l3b = mk_line(64'h3B3B_0000_0000_0011, 64'h3B3B_0000_0000_0022,
                      64'h3B3B_0000_0000_0033, 64'h3B3B_0000_0000_0044);
        l4  = mk_line(64'h4040_4040_4040_0000, 64'h4040_4040_4040_0001,
                      64'h4040_4040_4040_0002, 64'h4040_4040_4040_0003);
        l6  = mk_line(64'h6666_0000_0000_0000, 64'h6666_0000_0000_0001,
                      64'h6666_0000_0000_0002, 64'h6666_0000_0000_0003);
        last_line = '0;

        rst_n            = 1'b0;
        bus.ic_miss      = 1'b0;
        bus.ic_miss_addr = '0;
        bus.flush        = 1'b0;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;
        #1;
        chk("rst_req",  256'(bus.mem_req), 256'd0);
        chk("rst_addr", 256'(bus.mem_addr), 256'd0);
        chk("rst_ack",  256'(bus.ic_miss_ack), 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_data", bus.ic_fill_data, 256'd0);
        tick();
        tick();

        // T1: minimum-latency fill; miss taken on first edge with reset released
        rst_n            = 1'b1;
        bus.ic_miss      = 1'b1;
        bus.ic_miss_addr = 32'h0000_1A40;
        bus.mem_gnt      = 1'b1;
        tick();
        bus.ic_miss = 1'b0;
        chk("t1_req",  256'(bus.mem_req), 256'd1);
        chk("t1_addr", 256'(bus.mem_addr), 256'h0000_1A40);
        chk("t1_busy", 256'(bus.busy), 256'd1);
        tick();
        bus.mem_gnt = 1'b0;
        chk("t1_req_drop", 256'(bus.mem_req), 256'd0);
        feed_beats(l1, 1'b0);
        expect_ack("t1");
        tick();
        chk("t1_ack_pulse", 256'(bus.ic_miss_ack), 256'd0);
        chk("t1_hold_busy", 256'(bus.busy), 256'd1);
        chk("t1_hold_data", bus.ic_fill_data, l1);
        tick();
        chk("t1_idle_busy", 256'(bus.busy), 256'd0);

        // T2: grant delayed 3 cycles, gaps between beats
        start_miss(32'hDEAD_BEE0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_req_%0d", i),  256'(bus.mem_req), 256'd1);
            chk($sformatf("t2_addr_%0d", i), 256'(bus.mem_addr), 256'hDEAD_BEE0);
            if (i == 3) bus.mem_gnt = 1'b1;
            tick();
        end
        bus.mem_gnt = 1'b0;
        chk("t2_req_drop", 256'(bus.mem_req), 256'd0);
        feed_beats(l2, 1'b1);
        expect_ack("t2");
        tick();
        chk("t2_ack_pulse", 256'(bus.ic_miss_ack), 256'd0);
        tick();

        // T5: spurious beats in IDLE leave the line untouched
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        bus.mem_rvalid = 1'b0;
        chk("t5_data", bus.ic_fill_data, l2);
        chk("t5_busy", 256'(bus.busy), 256'd0);

        // T3: miss held through ACK/HOLD; re-request only after IDLE
        bus.ic_miss      = 1'b1;
        bus.ic_miss_addr = 32'h0001_0100;
        tick();
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        feed_beats(l3a, 1'b0);
        expect_ack("t3a");
        chk("t3_ack_req", 256'(bus.mem_req), 256'd0);
        tick();
        chk("t3_hold_req", 256'(bus.mem_req), 256'd0);
        tick();
        chk("t3_idle_req",  256'(bus.mem_req), 256'd0);
        chk("t3_idle_busy", 256'(bus.busy), 256'd0);
        tick();
        bus.ic_miss = 1'b0;
        chk("t3_rereq",  256'(bus.mem_req), 256'd1);
        chk("t3_readdr", 256'(bus.mem_addr), 256'h0001_0100);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        feed_beats(l3b, 1'b0);
        expect_ack("t3b");
        tick();
        tick();

        // T4: async reset after beat 2, then a clean refill
        start_miss(32'h0000_2000);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hCCCC_0000_0000_0000;
        tick();
        bus.mem_rdata  = 64'hCCCC_0000_0000_0001;
        tick();
        bus.mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t4_req",  256'(bus.mem_req), 256'd0);
        chk("t4_addr", 256'(bus.mem_addr), 256'd0);
        chk("t4_ack",  256'(bus.ic_miss_ack), 256'd0);
        chk("t4_busy", 256'(bus.busy), 256'd0);
        chk("t4_data", bus.ic_fill_data, 256'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t4_no_ack", 256'(bus.ic_miss_ack), 256'd0);
        start_miss(32'h0000_2000);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        feed_beats(l4, 1'b0);
        expect_ack("t4");
        tick();
        tick();

        // T6: flush during beat 1
        start_miss(32'h0000_3000);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
`ifndef IC_FILL_FLUSH_EN
        sb.push_back(l6);
`endif
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = l6[64*i +: 64];
            bus.flush      = (i == 1);
            tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.flush      = 1'b0;
`ifdef IC_FILL_FLUSH_EN
        chk("t6_ack_suppr", 256'(bus.ic_miss_ack), 256'd0);
        chk("t6_ack_busy",  256'(bus.busy), 256'd1);
        tick();
        chk("t6_hold_ack",  256'(bus.ic_miss_ack), 256'd0);
        chk("t6_hold_busy", 256'(bus.busy), 256'd1);
        tick();
        chk("t6_idle_busy", 256'(bus.busy), 256'd0);
        // Miss coincident with flush in IDLE is dropped
        bus.flush = 1'b1;
        start_miss(32'h0000_4000);
        bus.flush = 1'b0;
        chk("t6_drop_req",  256'(bus.mem_req), 256'd0);
        chk("t6_drop_busy", 256'(bus.busy), 256'd0);
`else
        expect_ack("t6");
        tick();
        tick();
        chk("t6_idle_busy", 256'(bus.busy), 256'd0);
`endif
        chk("sb_empty", 256'(sb.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
